mmu_job_arbiter: RTL

MMU_JOB_ARBITER -- requirements
Module: mmu_job_arbiter

---
 rtl/mmu_job_arbiter_pkg.sv | 27 ++
 rtl/mmu_job_arbiter_rr.sv | 43 ++++
 rtl/mmu_job_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mmu_job_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mmu_job_arbiter_pkg
// Shared types and constants for the matrix-multiply job arbiter: FSM state
// enum, requester/element geometry and a byte-lane extraction helper.
// -----------------------------------------------------------------------------
package mmu_job_arbiter_pkg;

    localparam int N_REQ  = 2;   // number of requesters
    localparam int N_ELEM = 4;   // elements per 2x2 matrix
    localparam int ELEM_W = 8;   // element width in bits

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_READ  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_RESP  = 3'd5
    } arb_state_t;

    // Element idx of a packed matrix word (element i lives in byte i).
    function automatic logic [ELEM_W-1:0] get_elem(input logic [N_ELEM*ELEM_W-1:0] word,
                                                   input logic [1:0]               idx);
        return word[idx*ELEM_W +: ELEM_W];
    endfunction

endpackage

// File: rtl/mmu_job_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant logic with a registered priority pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   request    : per-requester request bits
//   advance    : the current grant is being taken this cycle
//   grant      : one-hot combinational grant
// The pointer only moves on a contested grant, so a requester served alone
// does not lose its turn at the next contention.
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] request,
    input  logic       advance,
    output logic [1:0] grant
);

    logic r_prio;  // requester favoured when both request (0 after reset)

    // Grant decode: single requester wins outright, contention follows pointer.
    always_comb begin
        grant = 2'b00;
        case (request)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_prio ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Pointer update: after a contested grant, favour the loser next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (advance && (request == 2'b11)) begin
            r_prio <= grant[0];
        end else begin
            r_prio <= r_prio;
        end
    end

endmodule

// File: rtl/mmu_job_arbiter.sv
// -----------------------------------------------------------------------------
// mmu_job_arbiter
// Accepts 2x2 matrix-multiply jobs from two requesters, streams A and B into
// a shared engine, waits, reads back C and returns one response per job.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester job handshake; req_a/req_b byte i = elem i
//   resp_*              : response handshake with id, C (byte i = elem i), error
//   eng_load_*          : engine operand load strobe, A/B select, index, data
//   eng_output_*        : engine result read strobe and element select
//   eng_out_data        : engine result byte (valid in the read cycle)
//   eng_done            : engine completion
// WAIT_CYC >= 1 and DONE_TMO >= 2 are assumed.
// -----------------------------------------------------------------------------
module mmu_job_arbiter
    import mmu_job_arbiter_pkg::*;
#(
    parameter int WAIT_CYC = 6,
    parameter int DONE_TMO = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_ELEM*ELEM_W-1:0] req_a [N_REQ],
    input  logic [N_ELEM*ELEM_W-1:0] req_b [N_REQ],
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic                     resp_id,
    output logic [N_ELEM*ELEM_W-1:0] resp_c,
    output logic                     resp_err,
    output logic                     eng_load_en,
    output logic                     eng_load_sel_ab,
    output logic [1:0]               eng_load_index,
    output logic [ELEM_W-1:0]        eng_in_data,
    output logic                     eng_output_en,
    output logic [1:0]               eng_output_sel,
    input  logic [ELEM_W-1:0]        eng_out_data,
    input  logic                     eng_done
);

    localparam int WAIT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam int TMO_W  = (DONE_TMO > 1) ? $clog2(DONE_TMO) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYC - 1);
    // The final READ cycle is the first timeout cycle, so DRAIN itself
    // counts DONE_TMO-1 cycles before giving up.
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(DONE_TMO - 2);

    arb_state_t                r_state;
    arb_state_t                w_state_nxt;
    logic [2:0]                r_ld_idx;
    logic [1:0]                r_rd_idx;
    logic [WAIT_W-1:0]         r_wait_cnt;
    logic [TMO_W-1:0]          r_tmo_cnt;
    logic [N_ELEM*ELEM_W-1:0]  r_a;
    logic [N_ELEM*ELEM_W-1:0]  r_b;
    logic [N_ELEM*ELEM_W-1:0]  r_c;
    logic                      r_id;
    logic                      r_err;
    logic [N_REQ-1:0]          w_grant;
    logic                      w_take;
    logic                      w_resp_enter;
    logic                      w_tmo_hit;

    rr_arb2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .request (req_valid),
        .advance (w_take),
        .grant   (w_grant)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and combinational engine/handshake outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_take          = 1'b0;
        w_resp_enter    = 1'b0;
        w_tmo_hit       = 1'b0;
        req_ready       = {N_REQ{1'b0}};
        resp_valid      = 1'b0;
        eng_load_en     = 1'b0;
        eng_load_sel_ab = 1'b0;
        eng_load_index  = 2'd0;
        eng_in_data     = {ELEM_W{1'b0}};
        eng_output_en   = 1'b0;
        eng_output_sel  = 2'd0;
        case (r_state)
            ST_IDLE: begin
                // rst_n gating keeps req_ready low while reset is held.
                req_ready = w_grant & {N_REQ{rst_n}};
                if (|w_grant) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                eng_load_en     = 1'b1;
                eng_load_sel_ab = r_ld_idx[2];
                eng_load_index  = r_ld_idx[1:0];
                eng_in_data     = get_elem(r_ld_idx[2] ? r_b : r_a, r_ld_idx[1:0]);
                if (r_ld_idx == 3'd7) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == WAIT_LAST) begin
                    w_state_nxt = ST_READ;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_READ: begin
                eng_output_en  = 1'b1;
                eng_output_sel = r_rd_idx;
                if (r_rd_idx == 2'd3) begin
                    if (eng_done) begin
                        w_resp_enter = 1'b1;
                        w_state_nxt  = ST_RESP;
                    end else begin
                        w_state_nxt  = ST_DRAIN;
                    end
                end else begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (eng_done) begin
                    w_resp_enter = 1'b1;
                    w_state_nxt  = ST_RESP;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_resp_enter = 1'b1;
                    w_tmo_hit    = 1'b1;
                    w_state_nxt  = ST_RESP;
                end else begin
                    w_state_nxt  = ST_DRAIN;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Per-state counters; each clears whenever its state is not active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_idx   <= 3'd0;
            r_rd_idx   <= 2'd0;
            r_wait_cnt <= {WAIT_W{1'b0}};
            r_tmo_cnt  <= {TMO_W{1'b0}};
        end else begin
            r_ld_idx   <= (r_state == ST_LOAD) ? r_ld_idx + 3'd1 : 3'd0;
            r_rd_idx   <= (r_state == ST_READ) ? r_rd_idx + 2'd1 : 2'd0;
            r_wait_cnt <= ((r_state == ST_WAIT) && (r_wait_cnt != WAIT_LAST))
                          ? r_wait_cnt + WAIT_W'(1) : {WAIT_W{1'b0}};
            r_tmo_cnt  <= ((r_state == ST_DRAIN) && (r_tmo_cnt != TMO_LAST))
                          ? r_tmo_cnt + TMO_W'(1) : {TMO_W{1'b0}};
        end
    end

    // Job payload: operands latched at grant, results captured during READ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= {(N_ELEM*ELEM_W){1'b0}};
            r_b   <= {(N_ELEM*ELEM_W){1'b0}};
            r_c   <= {(N_ELEM*ELEM_W){1'b0}};
            r_id  <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (w_take) begin
                r_a  <= req_a[w_grant[1]];
                r_b  <= req_b[w_grant[1]];
                r_id <= w_grant[1];
            end
            if (r_state == ST_READ) begin
                r_c[r_rd_idx*ELEM_W +: ELEM_W] <= eng_out_data;
            end
            if (w_resp_enter) begin
                r_err <= w_tmo_hit;
            end
        end
    end

    assign resp_id  = r_id;
    assign resp_c   = r_c;
    assign resp_err = r_err;

endmodule
